// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorting network: one compare-exchange layer per register
// stage, per-vector direction, and a whole-pipe stall on consumer backpressure.

module bitonic_cmp_ex #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             asc_i,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);
   logic swap;

   // Strict compares only, so equal keys stay where they are.
   assign swap = asc_i ? (a_i > b_i) : (a_i < b_i);
   assign lo_o = swap ? b_i : a_i;
   assign hi_o = swap ? a_i : b_i;
endmodule

module bitonic_sort_pipe #(
   parameter int WIDTH = 32,
   parameter int N     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_dir,
   input  logic [N*WIDTH-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_dir,
   output logic [N*WIDTH-1:0] out_data
);
   localparam int LOG    = $clog2(N);
   localparam int STAGES = LOG * (LOG + 1) / 2;

   logic                                adv;
   logic [STAGES-1:0]                   vld_q, dir_q;
   logic [STAGES-1:0][N-1:0][WIDTH-1:0] data_q, data_d;
   logic [STAGES:0]                     vld_pipe, dir_pipe;
   logic [STAGES:0][N-1:0][WIDTH-1:0]   key_pipe;

   // Index 0 is the input port, index s+1 is the output of register stage s.
   assign vld_pipe = {vld_q, in_valid};
   assign dir_pipe = {dir_q, in_dir};
   assign key_pipe = {data_q, in_data};

   assign out_valid = vld_pipe[STAGES];
   assign out_dir   = dir_pipe[STAGES];
   assign out_data  = key_pipe[STAGES];

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && rst_n;

   for (genvar p = 1; p <= LOG; p++) begin : g_ph
      for (genvar t = 0; t < p; t++) begin : g_ly
         localparam int S = (p - 1) * p / 2 + t;
         localparam int D = 1 << (p - 1 - t);
         for (genvar k = 0; k < N / 2; k++) begin : g_ce
            localparam int I  = (k / D) * 2 * D + (k % D);
            // Sub-blocks of size 2^p alternate orientation; the last phase is one block.
            localparam bit UP = ((I >> p) & 1) == 0;
            bitonic_cmp_ex #(.WIDTH(WIDTH)) u_ce (
               .a_i   (key_pipe[S][I]),
               .b_i   (key_pipe[S][I+D]),
               .asc_i (UP ^ dir_pipe[S]),
               .lo_o  (data_d[S][I]),
               .hi_o  (data_d[S][I+D])
            );
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= '0;
         dir_q  <= '0;
         data_q <= '0;
      end else if (adv) begin
         vld_q  <= vld_pipe[STAGES-1:0];
         dir_q  <= dir_pipe[STAGES-1:0];
         data_q <= data_d;
      end
   end
endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Bench for bitonic_sort_pipe (N=8, WIDTH=8): directed table, streaming,
// random backpressure and mid-flight reset against a simple sorting model.

module tb_bitonic_sort_pipe;
   localparam int N   = 8;
   localparam int W   = 8;
   localparam int LAT = 6;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_dir = 1'b0;
   logic [N*W-1:0] in_data = '0;
   logic           out_ready = 1'b1;
   logic           in_ready, out_valid, out_dir;
   logic [N*W-1:0] out_data;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   bitonic_sort_pipe #(.WIDTH(W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dir    (in_dir),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dir   (out_dir),
      .out_data  (out_data)
   );

   typedef struct {
      logic [N*W-1:0] din;
      logic           dir;
      logic [N*W-1:0] exp;
   } vec_t;

   typedef struct {
      logic [N*W-1:0] d;
      logic           dir;
   } item_t;

   vec_t  tbl[3];
   item_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: plain bubble sort of the unpacked keys in the requested order.
   function automatic logic [N*W-1:0] ref_sort(input logic [N*W-1:0] d, input logic dir);
      logic [W-1:0]   k[N];
      logic [W-1:0]   t;
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) k[i] = d[i*W +: W];
      for (int a = 0; a < N; a++)
         for (int b = 0; b < N - 1; b++)
            if (dir ? (k[b] < k[b+1]) : (k[b] > k[b+1])) begin
               t = k[b]; k[b] = k[b+1]; k[b+1] = t;
            end
      for (int i = 0; i < N; i++) r[i*W +: W] = k[i];
      return r;
   endfunction

   // Send one vector alone and check latency, result and single-cycle pulse.
   task automatic run_single(input string name, input logic [N*W-1:0] d,
                             input logic dir, input logic [N*W-1:0] exp);
      int lat;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_dir    = dir;
      #1 chk({name, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, LAT);
      chk({name, "_data"}, out_data, exp);
      chk({name, "_dir"}, out_dir, dir);
      @(negedge clk);
      chk({name, "_pulse"}, out_valid, 0);
   endtask

   task automatic run_stream(input string name, input int nvec, input bit bp);
      int             sent = 0;
      int             got  = 0;
      int             cyc  = 0;
      logic [N*W-1:0] cur_d, prev_d;
      logic           cur_dir, prev_dir;
      logic           prev_stall = 1'b0;
      item_t          it;
      sb.delete();
      cur_d   = {$urandom, $urandom};
      cur_dir = bp ? 1'($urandom_range(0, 1)) : 1'b0;
      while (got < nvec && cyc < 3000) begin
         @(negedge clk);
         if (prev_stall) begin
            chk({name, "_hold_valid"}, out_valid, 1);
            chk({name, "_hold_data"}, out_data, prev_d);
            chk({name, "_hold_dir"}, out_dir, prev_dir);
         end
         if (!bp && got > 0) chk({name, "_contig"}, out_valid, 1);
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid  = (sent < nvec);
         in_data   = cur_d;
         in_dir    = cur_dir;
         #1;
         chk({name, "_in_ready"}, in_ready, !out_valid || out_ready);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               $display("FAIL %s_extra: got unexpected output %h expected none", name, out_data);
            end else begin
               it = sb.pop_front();
               chk({name, "_data"}, out_data, ref_sort(it.d, it.dir));
               chk({name, "_dir"}, out_dir, it.dir);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            it.d = cur_d; it.dir = cur_dir;
            sb.push_back(it);
            sent++;
            cur_d   = {$urandom, $urandom};
            cur_dir = bp ? 1'($urandom_range(0, 1)) : ((sent % 2) == 1);
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_dir   = out_dir;
         cyc++;
      end
      in_valid = 1'b0;
      chk({name, "_count"}, got, nvec);
      chk({name, "_sb_empty"}, sb.size(), 0);
      out_ready = 1'b1;
      repeat (LAT + 2) begin
         @(negedge clk);
         chk({name, "_no_dup"}, out_valid, 0);
      end
   endtask

   initial begin
      int lat;
      // Keys written key7 first so key 0 lands in the low byte.
      tbl[0] = '{din: {8'h04, 8'h06, 8'h02, 8'h08, 8'h01, 8'h07, 8'h03, 8'h05}, dir: 1'b0,
                 exp: {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}};
      tbl[1] = '{din: {8'h04, 8'h06, 8'h02, 8'h08, 8'h01, 8'h07, 8'h03, 8'h05}, dir: 1'b1,
                 exp: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}};
      tbl[2] = '{din: {8'h01, 8'h7F, 8'h80, 8'h80, 8'h00, 8'hFF, 8'h00, 8'hFF}, dir: 1'b0,
                 exp: {8'hFF, 8'hFF, 8'h80, 8'h80, 8'h7F, 8'h01, 8'h00, 8'h00}};

      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_dir", out_dir, 0);
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) run_single($sformatf("tbl%0d", i), tbl[i].din, tbl[i].dir, tbl[i].exp);

      run_stream("stream", 20, 1'b0);
      run_stream("bp", 100, 1'b1);

      // Four vectors in flight, then a one-cycle reset.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         in_dir   = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_dir", out_dir, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = tbl[2].din;
      in_dir   = 1'b0;
      #1 chk("post_rst_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("post_rst_latency", lat, LAT);
      chk("post_rst_data", out_data, tbl[2].exp);
      chk("post_rst_dir", out_dir, 0);
      @(negedge clk);
      chk("post_rst_pulse", out_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/bitonic_sort_pipe.md
# bitonic_sort_pipe

Parametrised, fully pipelined bitonic sorting network for N unsigned WIDTH-bit keys. It generalises the two-input compare-exchange block into a complete N-input network with a per-vector sort direction and a valid/ready stream interface. It sits between a vector producer and its consumer and accepts one vector per cycle. The whole pipeline stalls on consumer backpressure.

## Interface
- WIDTH, 32, key width in bits (1..64)
- N, 8, keys per vector; power of two, 2..16
- STAGES, derived = log2(N)*(log2(N)+1)/2 (N=8 -> 6), not overridable
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  input vector present
- in_ready  out  1  block accepts input this cycle
- in_dir  in  1  0 = ascending, 1 = descending; sampled with the vector
- in_data  in  N*WIDTH  key i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  sorted vector present
- out_ready  in  1  consumer accepts output this cycle
- out_dir  out  1  direction the output vector was sorted with
- out_data  out  N*WIDTH  sorted keys, same packing as in_data

## Operation
- Network: standard bitonic merge network. log2(N) merge phases; phase p has p compare-exchange layers. Each layer is one register stage, so there are STAGES stages.
- Each stage holds a valid bit, a dir bit and N keys. dir travels with its vector, so consecutive vectors may use different directions.
- Compare-exchange: unsigned compare. The swap orientation per pair follows the bitonic sub-sequence rule, with the final orientation set by the vector's dir bit.
  - Swap only on strict inequality. Equal keys are never swapped.
- Result for ascending (dir=0): key 0 is the minimum and key N-1 is the maximum.
- Result for descending (dir=1): key 0 is the maximum.
- Output is a permutation of the input. The multiset of keys is preserved bit-exactly.
- Advance condition: adv = !out_valid | out_ready.
  - When adv=1, every stage loads from the previous one, and stage 0 loads {in_valid, in_dir, in_data}.
  - When adv=0, all stages hold.
- in_ready = adv & rst_n. It is combinational from out_ready; there is no skid buffer.
- Transfers: input is taken when in_valid & in_ready; output is consumed when out_valid & out_ready.
- Bubbles: stages with valid=0 still shift when adv=1. Bubbles do not throttle throughput.
- No internal FSM beyond the valid-bit shift chain. The block is a pure stall-able pipeline.

## Timing
- Latency: a vector accepted at edge k appears on out_* after edge k+STAGES-1, i.e. it is visible in the cycle after edge k+STAGES-1 when no stall occurs.
  - N=8: 6 cycles from acceptance to out_valid.
- Throughput: one vector per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - in_ready=0;
  - all state, including out_data and out_dir, is held stable;
  - a held vector must not change until it is consumed.
- Simultaneous consume and accept in the same cycle is legal; no bubble is inserted.
- Reset (rst_n=0 at a rising edge):
  - all valid bits clear; out_valid=0;
  - out_data=0, out_dir=0, all stage data regs = 0;
  - in_ready=0 while rst_n=0.
- Reset mid-operation: all in-flight vectors are dropped. No partial vector is ever output.
  - First acceptance is possible in the first cycle with rst_n=1; the first output follows STAGES cycles later.
- out_* are registered outputs with no combinational path from in_*. in_ready depends combinationally on out_ready only.
- Data and dir of invalid stages are don't-care, except out_data/out_dir after reset (zero).

## Test plan
- N=8, WIDTH=8: in_data keys 0..7 = 5,3,7,1,8,2,6,4, dir=0, out_ready=1 -> after 6 cycles out_valid=1, keys 1,2,3,4,5,6,7,8, out_dir=0, a single-cycle pulse.
- Same vector with dir=1 -> keys 8,7,6,5,4,3,2,1, out_dir=1.
- Extremes and ties: keys FF,00,FF,00,80,80,7F,01 with dir=0 -> 00,00,01,7F,80,80,FF,FF.
- Streaming: 20 back-to-back random vectors with alternating dir, out_ready=1 -> 20 consecutive out_valid cycles, in order. Each output is sorted in its own dir and is a permutation of its input.
- Backpressure: out_ready toggled randomly (about 50%) over 100 random vectors:
  - no loss, duplication or reordering;
  - out_data is stable while stalled;
  - in_ready tracks !out_valid | out_ready every cycle.
- Reset mid-flight: 4 vectors in flight, rst_n=0 for 1 cycle:
  - out_valid=0 and out_data=0 next cycle;
  - no stale vector emerges;
  - a new vector accepted right after reset appears 6 cycles later, correctly sorted.
